mem_write_buffer: RTL and testbench

Avalon-MM write master with an internal buffering FIFO; the write-side counterpart of the image-pipeline read buffer. User logic pushes words into the FIFO. The master drains them to a contiguous memory region, starting at `control_write_base`, for `control_write_length` bytes. It sits at the tail of the ISP datapath and writes processed pixels back to SDRAM.

---
 rtl/isp_mem_pkg.sv | 10 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/mem_write_buffer.sv | 82 ++++++++
 tb/tb_mem_write_buffer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/isp_mem_pkg.sv
// Shared types and default widths for the ISP memory read/write buffers.
package isp_mem_pkg;
  typedef enum logic {IDLE, RUN} state_t;

  localparam int DEF_DATAWIDTH      = 32;
  localparam int DEF_BYTEENABLEWIDTH = DEF_DATAWIDTH / 8;
  localparam int DEF_ADDRESSWIDTH   = 30;
  localparam int DEF_FIFODEPTH      = 32;
  localparam int DEF_FIFODEPTH_LOG2 = 5;
endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; the head word is read straight from registered storage.
module sync_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 32,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      d,
  input  logic                  pop,
  output logic [WIDTH-1:0]      q,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);
  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_push;
  logic                  w_pop;

  // full/empty come from the start-of-cycle count, so a push while full is lost
  // even when a pop happens on the same edge
  assign full  = (r_count == (DEPTH_LOG2+1)'(DEPTH));
  assign empty = (r_count == '0);
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign q      = r_mem[r_rd_ptr];
  assign count  = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/mem_write_buffer.sv
// Avalon-MM write master draining a buffering FIFO into a contiguous memory region.
module mem_write_buffer
  import isp_mem_pkg::*;
#(
  parameter int DATAWIDTH       = DEF_DATAWIDTH,
  parameter int BYTEENABLEWIDTH = DEF_BYTEENABLEWIDTH,
  parameter int ADDRESSWIDTH    = DEF_ADDRESSWIDTH,
  parameter int FIFODEPTH       = DEF_FIFODEPTH,
  parameter int FIFODEPTH_LOG2  = DEF_FIFODEPTH_LOG2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDRESSWIDTH-1:0]    control_write_base,
  input  logic [ADDRESSWIDTH-1:0]    control_write_length,
  input  logic                       control_go,
  output logic                       control_done,
  input  logic                       user_write_buffer,
  input  logic [DATAWIDTH-1:0]       user_buffer_data,
  output logic                       user_buffer_full,
  output logic [FIFODEPTH_LOG2:0]    user_buffer_count,
  output logic [ADDRESSWIDTH-1:0]    master_address,
  output logic                       master_write,
  output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
  output logic [DATAWIDTH-1:0]       master_writedata,
  input  logic                       master_waitrequest
);
  localparam logic [ADDRESSWIDTH-1:0] STEP = ADDRESSWIDTH'(BYTEENABLEWIDTH);

  state_t                  r_state;
  logic [ADDRESSWIDTH-1:0] r_address;
  logic [ADDRESSWIDTH-1:0] r_length;
  logic [ADDRESSWIDTH-1:0] w_eff_len;
  logic                    w_empty;
  logic                    w_accept;

  // partial trailing words are not written
  assign w_eff_len = control_write_length & ~(STEP - 1'b1);
  assign w_accept  = master_write & ~master_waitrequest;

  assign control_done      = (r_state == IDLE);
  assign master_write      = (r_state == RUN) & ~w_empty;
  assign master_address    = r_address;
  assign master_byteenable = '1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_address <= '0;
      r_length  <= '0;
    end else begin
      case (r_state)
        IDLE: if (control_go && w_eff_len != '0) begin
          r_state   <= RUN;
          r_address <= control_write_base;
          r_length  <= w_eff_len;
        end
        RUN: if (w_accept) begin
          r_address <= r_address + STEP;
          r_length  <= r_length - STEP;
          if (r_length == STEP) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH      (DATAWIDTH),
    .DEPTH      (FIFODEPTH),
    .DEPTH_LOG2 (FIFODEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (user_write_buffer),
    .d     (user_buffer_data),
    .pop   (w_accept),
    .q     (master_writedata),
    .count (user_buffer_count),
    .full  (user_buffer_full),
    .empty (w_empty)
  );
endmodule

// File: tb/tb_mem_write_buffer.sv
// Directed bench for mem_write_buffer with hand-computed expectations.
module tb_mem_write_buffer;
  logic        clk = 0;
  logic        reset;
  logic [29:0] control_write_base;
  logic [29:0] control_write_length;
  logic        control_go;
  logic        control_done;
  logic        user_write_buffer;
  logic [31:0] user_buffer_data;
  logic        user_buffer_full;
  logic [5:0]  user_buffer_count;
  logic [29:0] master_address;
  logic        master_write;
  logic [3:0]  master_byteenable;
  logic [31:0] master_writedata;
  logic        master_waitrequest;

  int n_checks = 0;
  int n_fail   = 0;
  logic [29:0] la[$];
  logic [31:0] ld[$];

  mem_write_buffer dut (
    .clk(clk), .reset(reset),
    .control_write_base(control_write_base),
    .control_write_length(control_write_length),
    .control_go(control_go), .control_done(control_done),
    .user_write_buffer(user_write_buffer), .user_buffer_data(user_buffer_data),
    .user_buffer_full(user_buffer_full), .user_buffer_count(user_buffer_count),
    .master_address(master_address), .master_write(master_write),
    .master_byteenable(master_byteenable), .master_writedata(master_writedata),
    .master_waitrequest(master_waitrequest)
  );

  always #5 clk = ~clk;

  // log every write that the slave accepts on the coming edge
  always @(negedge clk) begin
    if (!reset && master_write && !master_waitrequest) begin
      la.push_back(master_address);
      ld.push_back(master_writedata);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] d);
    user_write_buffer = 1; user_buffer_data = d;
    tick();
    user_write_buffer = 0;
  endtask

  task automatic go(input logic [29:0] base, input logic [29:0] len);
    control_go = 1; control_write_base = base; control_write_length = len;
    tick();
    control_go = 0;
  endtask

  task automatic clr_log();
    la.delete(); ld.delete();
  endtask

  initial begin
    reset = 1; control_go = 0; control_write_base = 0; control_write_length = 0;
    user_write_buffer = 0; user_buffer_data = 0; master_waitrequest = 0;
    tick(); tick();
    reset = 0;
    check("rst_done", control_done, 1);
    check("rst_write", master_write, 0);
    check("rst_addr", master_address, 0);
    check("rst_count", user_buffer_count, 0);
    check("rst_full", user_buffer_full, 0);
    check("byteenable", master_byteenable, 4'hF);

    // basic transfer
    for (int i = 0; i < 4; i++) push(32'hA0 + i);
    check("prefill_count", user_buffer_count, 4);
    clr_log();
    go(30'h100, 30'd16);
    check("go_write", master_write, 1);
    check("go_addr", master_address, 30'h100);
    check("go_data", master_writedata, 32'hA0);
    tick(); tick(); tick();
    check("basic_notdone", control_done, 0);
    tick();
    check("basic_done", control_done, 1);
    check("basic_empty", user_buffer_count, 0);
    check("basic_n", la.size(), 4);
    for (int i = 0; i < 4 && i < la.size(); i++) begin
      check("basic_addr", la[i], 30'h100 + 4 * i);
      check("basic_data", ld[i], 32'hA0 + i);
    end

    // waitrequest stall
    push(32'hB0); push(32'hB1);
    clr_log();
    master_waitrequest = 1;
    go(30'h40, 30'd8);
    for (int i = 0; i < 3; i++) begin
      check("wr_write", master_write, 1);
      check("wr_addr", master_address, 30'h40);
      check("wr_data", master_writedata, 32'hB0);
      tick();
    end
    master_waitrequest = 0;
    tick(); tick();
    check("wr_done", control_done, 1);
    check("wr_n", la.size(), 2);
    if (la.size() == 2) begin
      check("wr_a0", la[0], 30'h40); check("wr_d0", ld[0], 32'hB0);
      check("wr_a1", la[1], 30'h44); check("wr_d1", ld[1], 32'hB1);
    end

    // full, then simultaneous push/pop while full
    for (int i = 0; i < 33; i++) push(32'hC00 + i);
    check("full_count", user_buffer_count, 32);
    check("full_flag", user_buffer_full, 1);
    clr_log();
    go(30'h300, 30'd8);
    user_write_buffer = 1; user_buffer_data = 32'hDEAD;
    tick();
    user_write_buffer = 0;
    check("pp_count", user_buffer_count, 31);
    check("pp_full", user_buffer_full, 0);
    tick();
    check("pp_done", control_done, 1);
    check("pp_count2", user_buffer_count, 30);
    clr_log();
    go(30'h400, 30'd120);
    for (int i = 0; i < 30; i++) tick();
    check("drain_done", control_done, 1);
    check("drain_count", user_buffer_count, 0);
    check("drain_n", la.size(), 30);
    if (la.size() == 30) begin
      check("drain_d0", ld[0], 32'hC02);
      check("drain_dlast", ld[29], 32'hC1F);
      check("drain_alast", la[29], 30'h474);
    end

    // length 0
    push(32'hD0);
    clr_log();
    go(30'h500, 30'd0);
    check("len0_done", control_done, 1);
    check("len0_write", master_write, 0);
    tick();
    check("len0_write2", master_write, 0);
    check("len0_count", user_buffer_count, 1);

    // length 6 -> one word
    push(32'hD1);
    go(30'h600, 30'd6);
    check("len6_addr", master_address, 30'h600);
    check("len6_data", master_writedata, 32'hD0);
    tick();
    check("len6_done", control_done, 1);
    check("len6_count", user_buffer_count, 1);
    check("len6_n", la.size(), 1);

    // go during RUN is ignored
    clr_log();
    go(30'h700, 30'd8);
    tick();
    check("rearm_write", master_write, 0);
    go(30'h800, 30'd8);
    check("rearm_busy", control_done, 0);
    check("rearm_addr", master_address, 30'h704);
    push(32'hD2);
    check("rearm_data", master_writedata, 32'hD2);
    check("rearm_wr", master_write, 1);
    tick();
    check("rearm_done", control_done, 1);
    check("rearm_n", la.size(), 2);
    if (la.size() == 2) check("rearm_a0", la[0], 30'h700);

    // underflow stall, sparse pushes
    clr_log();
    go(30'h900, 30'd12);
    for (int i = 0; i < 3; i++) begin
      check("uf_idle_wr", master_write, 0);
      tick(); tick();
      check("uf_idle_wr2", master_write, 0);
      push(32'hE0 + i);
      check("uf_wr", master_write, 1);
      check("uf_addr", master_address, 30'h900 + 4 * i);
      check("uf_data", master_writedata, 32'hE0 + i);
      tick();
    end
    check("uf_done", control_done, 1);
    check("uf_n", la.size(), 3);

    // reset mid-transfer
    for (int i = 0; i < 8; i++) push(32'hF0 + i);
    clr_log();
    go(30'hA00, 30'd32);
    tick(); tick();
    check("mid_n", la.size(), 2);
    reset = 1;
    tick();
    reset = 0;
    check("mid_done", control_done, 1);
    check("mid_write", master_write, 0);
    check("mid_addr", master_address, 0);
    check("mid_count", user_buffer_count, 0);
    check("mid_full", user_buffer_full, 0);
    clr_log();
    push(32'h55);
    go(30'h200, 30'd4);
    check("post_addr", master_address, 30'h200);
    check("post_data", master_writedata, 32'h55);
    tick();
    check("post_done", control_done, 1);
    check("post_n", la.size(), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
